// File: rtl/block_accumulator.sv
// block_accumulator: requests one block from the upstream multiplier, sums the
// streamed words, and holds the result until downstream accepts it.
// Optional feature: define BLOCK_ACC_SAT32_EN to present sums above 32 bits as
// 0xFFFF_FFFF with sat set (accumulation itself stays full width).
module block_accumulator #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int ACC_WIDTH = 40,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       EN_blockRead,
  input  logic                       VALID_memVal,
  input  logic [WIDTH-1:0]           memVal_data,
  output logic                       busy,
  output logic [ACC_WIDTH-1:0]       sum,
  output logic [$clog2(DEPTH):0]     word_count,
  output logic                       sum_valid,
  input  logic                       sum_ready,
  output logic                       err_timeout,
  output logic                       sat
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 sv_q, sv_d;
  logic                 err_q, err_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH-1:0] word_ext;

  // Converts the final accumulator into the presented {sat, sum} pair.
  function automatic logic [ACC_WIDTH:0] present(input logic [ACC_WIDTH-1:0] a);
`ifdef BLOCK_ACC_SAT32_EN
    if (ACC_WIDTH > 32 && (a >> 32) != '0)
      return {1'b1, ACC_WIDTH'(64'hFFFF_FFFF)};
    return {1'b0, a};
`else
    return {1'b0, a};
`endif
  endfunction

  assign word_ext = ACC_WIDTH'(memVal_data);

  // Next-state and next-output computation for the block FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    en_d    = en_q;
    busy_d  = busy_q;
    sum_d   = sum_q;
    sv_d    = sv_q;
    err_d   = err_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          sat_d   = 1'b0;
          sum_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (VALID_memVal) begin
          acc_d   = word_ext;
          cnt_d   = CW'(1);
          en_d    = 1'b0;
          if (CW'(1) == CW'(DEPTH)) begin
            state_d        = S_DONE;
            sv_d           = 1'b1;
            {sat_d, sum_d} = present(word_ext);
          end else begin
            state_d = S_COLLECT;
          end
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          // No word ever came: report an empty, flagged result.
          en_d    = 1'b0;
          err_d   = 1'b1;
          sum_d   = '0;
          sat_d   = 1'b0;
          sv_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_COLLECT: begin
        if (VALID_memVal) begin
          acc_d = acc_q + word_ext;
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(DEPTH)) begin
            state_d        = S_DONE;
            sv_d           = 1'b1;
            {sat_d, sum_d} = present(acc_d);
          end
        end else begin
          // First gap closes the block.
          state_d        = S_DONE;
          sv_d           = 1'b1;
          {sat_d, sum_d} = present(acc_q);
        end
      end
      S_DONE: begin
        // Result held; words and start pulses arriving here are ignored.
        if (sv_q && sum_ready) begin
          sv_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      sum_q   <= '0;
      sv_q    <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      sum_q   <= sum_d;
      sv_q    <= sv_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end

  assign EN_blockRead = en_q;
  assign busy         = busy_q;
  assign sum          = sum_q;
  assign word_count   = cnt_q;
  assign sum_valid    = sv_q;
  assign err_timeout  = err_q;
  assign sat          = sat_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Self-checking bench for block_accumulator: directed corner blocks plus
// random blocks, compared against a plain-arithmetic model of the block sum.
module tb_block_accumulator;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 64;
  localparam int ACC_WIDTH = 40;
  localparam int TIMEOUT   = 255;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   en;
  logic                   valid;
  logic [WIDTH-1:0]       data;
  logic                   busy;
  logic [ACC_WIDTH-1:0]   sum;
  logic [$clog2(DEPTH):0] word_count;
  logic                   sv;
  logic                   ready;
  logic                   err;
  logic                   sat;

  int checks   = 0;
  int failures = 0;
  logic [31:0] wq[$];

  block_accumulator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_WIDTH(ACC_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .EN_blockRead(en), .VALID_memVal(valid),
    .memVal_data(data), .busy(busy), .sum(sum), .word_count(word_count),
    .sum_valid(sv), .sum_ready(ready), .err_timeout(err), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},   64'(en), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_sum"},  64'(sum), 0);
    chk({tag, "_cnt"},  64'(word_count), 0);
    chk({tag, "_sv"},   64'(sv), 0);
    chk({tag, "_err"},  64'(err), 0);
    chk({tag, "_sat"},  64'(sat), 0);
  endtask

  // Runs one block streaming wq, holds sum_ready low for 'hold' cycles, then handshakes.
  task automatic do_block(input string tag, input int hold);
    longint unsigned s;
    logic [63:0]     es;
    logic            esat;
    int              n;
    n = wq.size();
    s = 0;
    foreach (wq[i]) s += longint'(wq[i]);
    es   = s;
    esat = 1'b0;
`ifdef BLOCK_ACC_SAT32_EN
    if (s > 64'hFFFF_FFFF) begin es = 64'hFFFF_FFFF; esat = 1'b1; end
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_en_rise"}, 64'(en), 1);
    chk({tag, "_busy"}, 64'(busy), 1);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      data  = wq[i];
      @(negedge clk);
    end
    valid = 1'b0;
    data  = $urandom;
    if (n < DEPTH) begin
      chk({tag, "_sv_before_gap"}, 64'(sv), 0);
      @(negedge clk);
    end
    chk({tag, "_sv"},   64'(sv), 1);
    chk({tag, "_sum"},  64'(sum), es);
    chk({tag, "_cnt"},  64'(word_count), 64'(n));
    chk({tag, "_err"},  64'(err), 0);
    chk({tag, "_sat"},  64'(sat), 64'(esat));
    chk({tag, "_en_low"}, 64'(en), 0);
    for (int c = 0; c < hold; c++) begin
      valid = 1'($urandom);
      data  = $urandom;
      start = 1'($urandom);
      @(negedge clk);
      chk({tag, "_hold_sv"},  64'(sv), 1);
      chk({tag, "_hold_sum"}, 64'(sum), es);
      chk({tag, "_hold_cnt"}, 64'(word_count), 64'(n));
      chk({tag, "_hold_sat"}, 64'(sat), 64'(esat));
    end
    valid = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    chk({tag, "_ack_sv"},   64'(sv), 0);
    chk({tag, "_ack_busy"}, 64'(busy), 0);
    @(negedge clk);
    chk({tag, "_no_restart"}, 64'(busy), 0);
  endtask

  initial begin
    int en_cycles;
    rst = 1'b1; start = 1'b1; valid = 1'b0; data = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // 64 ones: block ends on the DEPTH-th word.
    wq.delete();
    repeat (64) wq.push_back(32'd1);
    do_block("ones64", 0);

    // 10 words of 0x10 closed by a gap.
    wq.delete();
    repeat (10) wq.push_back(32'h10);
    do_block("ten16", 0);

    // All-ones words: full-width sum or saturation.
    wq.delete();
    repeat (64) wq.push_back(32'hFFFF_FFFF);
    do_block("max64", 0);

    // Downstream stalls for 20 cycles.
    wq.delete();
    repeat (7) wq.push_back($urandom);
    do_block("stall20", 20);

    // Timeout: no words ever arrive.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_cycles = 0;
    for (int c = 0; c < 400 && !sv; c++) begin
      if (en) en_cycles++;
      @(negedge clk);
    end
    chk("tmo_sv", 64'(sv), 1);
    chk("tmo_en_cycles", 64'(en_cycles), 64'(TIMEOUT));
    chk("tmo_en_low", 64'(en), 0);
    chk("tmo_err", 64'(err), 1);
    chk("tmo_sum", 64'(sum), 0);
    chk("tmo_cnt", 64'(word_count), 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("tmo_ack_busy", 64'(busy), 0);

    // Reset in the middle of COLLECT, then a fresh block.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      valid = 1'b1;
      data  = $urandom;
      @(negedge clk);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0; start = 1'b0; valid = 1'b0;
    @(negedge clk);
    wq.delete();
    repeat (5) wq.push_back(32'd2);
    do_block("after_rst", 0);

    // Random blocks of random length and content.
    for (int b = 0; b < 12; b++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(((b % 3) == 0) ? 32'hFFFF_FFFF - ($urandom % 16) : $urandom);
      do_block("rand", $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_accumulator.md
BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the width of each streamed memory word.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the maximum number of words per block.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, meaning the accumulator and sum width; it SHALL be at least WIDTH+log2(DEPTH).
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for the first word.
REQ-005 SHALL have port clk, input, 1 bit, system clock; every register SHALL update on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-007 SHALL have port start, input, 1 bit, requests one block reduction.
REQ-008 SHALL have port EN_blockRead, output, 1 bit, block-read request to the upstream multiplier.
REQ-009 SHALL have port VALID_memVal, input, 1 bit, upstream word-valid strobe.
REQ-010 SHALL have port memVal_data, input, WIDTH bits, upstream word, unsigned.
REQ-011 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-012 SHALL have port sum, output, ACC_WIDTH bits, block sum.
REQ-013 SHALL have port word_count, output, log2(DEPTH)+1 bits, number of words accumulated.
REQ-014 SHALL have port sum_valid, output, 1 bit, result-available flag.
REQ-015 SHALL have port sum_ready, input, 1 bit, downstream accepts the result.
REQ-016 SHALL have port err_timeout, output, 1 bit, result ended by timeout.
REQ-017 SHALL have port sat, output, 1 bit, result was saturated.

Function
REQ-018 SHALL implement the states IDLE, REQ, COLLECT and DONE.
REQ-019 In IDLE, a start pulse SHALL clear the accumulator, word_count, err_timeout, sat and the timeout counter, then go to REQ; start SHALL be ignored in every other state.
REQ-020 EN_blockRead SHALL be high exactly while in REQ, registered, so that it rises one cycle after start is sampled.
REQ-021 In REQ, VALID_memVal high SHALL accumulate that cycle's word and go to COLLECT.
REQ-022 In REQ, if TIMEOUT cycles pass without a valid word, the block SHALL set err_timeout and go to DONE with sum=0 and word_count=0.
REQ-023 In COLLECT, each cycle with VALID_memVal high SHALL add memVal_data, zero-extended, to the accumulator and increment word_count.
REQ-024 COLLECT SHALL go to DONE on the cycle word_count reaches DEPTH, or on the first cycle VALID_memVal is low.
REQ-025 A valid word arriving in DONE or IDLE SHALL be discarded.
REQ-026 sum_valid SHALL assert on the cycle after the final word or the gap that ends the block.
REQ-027 sum, word_count, err_timeout and sat SHALL remain stable while sum_valid is high.
REQ-028 DONE SHALL hold until sum_valid and sum_ready are both high; on that cycle the block SHALL return to IDLE and drop sum_valid on the next edge.
REQ-029 start high on the handshake cycle SHALL NOT begin a new block; it SHALL be resampled in IDLE.
REQ-030 The accumulator SHALL never wrap with the default parameters, since 64 words of 0xFFFFFFFF sum to 0x3F_FFFF_FFC0.

Reset
REQ-031 On rst high, the state SHALL become IDLE and all outputs SHALL be 0: EN_blockRead, busy, sum, word_count, sum_valid, err_timeout and sat.
REQ-032 rst SHALL override any in-progress REQ, COLLECT or DONE, and partial sums SHALL be discarded.
REQ-033 rst SHALL take priority over start in the same cycle.

Configuration
REQ-034 With macro BLOCK_ACC_SAT32_EN defined, a final sum above 0xFFFF_FFFF SHALL be presented as 0x0000_FFFF_FFFF, with sat high, while internal accumulation stays full width.
REQ-035 Without BLOCK_ACC_SAT32_EN, sum SHALL be the full ACC_WIDTH value and sat SHALL be tied to 0.

Verification
REQ-036 The bench SHALL cover: start, then 64 valid words each equal to 1 -> sum=64, word_count=64, sum_valid asserted one cycle after the 64th word, err_timeout=0.
REQ-037 The bench SHALL cover: start, then 10 words of 0x10, then VALID_memVal low -> sum=0xA0, word_count=10.
REQ-038 The bench SHALL cover: start with no VALID_memVal for 255 cycles -> EN_blockRead drops, err_timeout=1, sum=0, sum_valid=1.
REQ-039 The bench SHALL cover: 64 words of 0xFFFFFFFF -> sum=0x3F_FFFF_FFC0 without the macro; sum=0xFFFFFFFF and sat=1 with BLOCK_ACC_SAT32_EN.
REQ-040 The bench SHALL cover: sum_ready held low for 20 cycles after sum_valid -> outputs stable; sum_ready pulse -> IDLE and busy=0 on the next cycle.
REQ-041 The bench SHALL cover: rst asserted after 30 words in COLLECT -> all outputs 0 the next cycle, and a fresh start with 5 words of 2 -> sum=10.
